// File: rtl/aes_key_expander.sv
// Iterative AES-128/192/256 key schedule: streams w[0..4(Nr+1)-1] one word per
// cycle over valid/ready, computing each word from an 8-word history window.

module sbox (
  input  logic [7:0] val,
  output logic [7:0] sub
);

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) begin
        p = p ^ aa;
      end else begin
        p = p;
      end
      aa = gf_xtime(aa);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; zero maps to zero naturally.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  logic [7:0] inv_s;

  // Inverse followed by the AES affine transform.
  always_comb begin
    inv_s = gf_inv(val);
    sub   = inv_s ^ {inv_s[6:0], inv_s[7]} ^ {inv_s[5:0], inv_s[7:6]}
                  ^ {inv_s[4:0], inv_s[7:5]} ^ {inv_s[3:0], inv_s[7:4]} ^ 8'h63;
  end

endmodule

module aes_key_expander #(
  parameter bit ENABLE_192 = 1'b1,
  parameter bit ENABLE_256 = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [255:0] key_in,
  output logic         start_ready,
  output logic         kw_valid,
  input  logic         kw_ready,
  output logic [31:0]  kw_data,
  output logic [5:0]   kw_index,
  output logic         kw_last,
  output logic         err
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  state_t           state_r, state_s;
  logic [7:0][31:0] win_r, win_s;
  logic [3:0]       nk_r, nk_s;
  logic [5:0]       last_idx_r, last_idx_s;
  logic [2:0]       mod_r, mod_s;
  logic [7:0]       rcon_r, rcon_s;
  logic             kw_valid_s, kw_last_s, err_s;
  logic [31:0]      kw_data_s;
  logic [5:0]       kw_index_s;

  logic             handshake_s, legal_s, wrap_s, past_key_s;
  logic [2:0]       mod_nx_s;
  logic [5:0]       idx_nx_s;
  logic [31:0]      sub_in_s, sub_out_s, temp_s, base_s, word_nx_s;

  // win_r[j] holds w[i-1-j]; before the key has fully streamed out, the key
  // words stand in as w[-Nk..-1], so w[i-Nk] always sits at win_r[Nk-1].
  assign handshake_s = kw_valid & kw_ready;
  assign legal_s     = (mode == 2'd0) || ((mode == 2'd1) && ENABLE_192)
                       || ((mode == 2'd2) && ENABLE_256);
  assign idx_nx_s    = kw_index + 6'd1;
  assign wrap_s      = ({1'b0, mod_r} == (nk_r - 4'd1));
  assign mod_nx_s    = wrap_s ? 3'd0 : (mod_r + 3'd1);
  assign past_key_s  = (idx_nx_s >= {2'b00, nk_r});
  assign sub_in_s    = (mod_nx_s == 3'd0) ? {kw_data[23:0], kw_data[31:24]} : kw_data;
  assign start_ready = (state_r == IDLE);

  sbox u_sbox_b0 (.val(sub_in_s[31:24]), .sub(sub_out_s[31:24]));
  sbox u_sbox_b1 (.val(sub_in_s[23:16]), .sub(sub_out_s[23:16]));
  sbox u_sbox_b2 (.val(sub_in_s[15:8]),  .sub(sub_out_s[15:8]));
  sbox u_sbox_b3 (.val(sub_in_s[7:0]),   .sub(sub_out_s[7:0]));

  // Next expanded word w[i+1] from the current word and the shifted window.
  always_comb begin
    temp_s    = kw_data;
    base_s    = win_r[6];
    word_nx_s = 32'h0;
    if (mod_nx_s == 3'd0) begin
      temp_s = sub_out_s ^ {rcon_r, 24'h000000};
    end else if ((nk_r == 4'd8) && (mod_nx_s == 3'd4)) begin
      temp_s = sub_out_s;
    end else begin
      temp_s = kw_data;
    end
    case (nk_r)
      4'd4:    base_s = win_r[2];
      4'd6:    base_s = win_r[4];
      default: base_s = win_r[6];
    endcase
    if (past_key_s) begin
      word_nx_s = base_s ^ temp_s;
    end else begin
      word_nx_s = base_s;
    end
  end

  // FSM next-state and register next values.
  always_comb begin
    state_s    = state_r;
    win_s      = win_r;
    nk_s       = nk_r;
    last_idx_s = last_idx_r;
    mod_s      = mod_r;
    rcon_s     = rcon_r;
    kw_valid_s = kw_valid;
    kw_data_s  = kw_data;
    kw_index_s = kw_index;
    kw_last_s  = kw_last;
    err_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && legal_s) begin
          state_s    = RUN;
          mod_s      = 3'd0;
          rcon_s     = 8'h01;
          kw_valid_s = 1'b1;
          kw_data_s  = key_in[255:224];
          kw_index_s = 6'd0;
          kw_last_s  = 1'b0;
          case (mode)
            2'd0: begin
              nk_s       = 4'd4;
              last_idx_s = 6'd43;
              win_s      = {128'h0, key_in[255:128]};
            end
            2'd1: begin
              nk_s       = 4'd6;
              last_idx_s = 6'd51;
              win_s      = {64'h0, key_in[255:64]};
            end
            default: begin
              nk_s       = 4'd8;
              last_idx_s = 6'd59;
              win_s      = key_in;
            end
          endcase
        end else if (start) begin
          err_s = 1'b1;
        end else begin
          err_s = 1'b0;
        end
      end
      RUN: begin
        if (handshake_s && kw_last) begin
          state_s    = IDLE;
          kw_valid_s = 1'b0;
          kw_last_s  = 1'b0;
        end else if (handshake_s) begin
          win_s      = {win_r[6:0], kw_data};
          mod_s      = mod_nx_s;
          kw_data_s  = word_nx_s;
          kw_index_s = idx_nx_s;
          kw_last_s  = (idx_nx_s == last_idx_r);
          if (past_key_s && (mod_nx_s == 3'd0)) begin
            rcon_s = xtime(rcon_r);
          end else begin
            rcon_s = rcon_r;
          end
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s    = IDLE;
        kw_valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      win_r      <= 256'h0;
      nk_r       <= 4'd4;
      last_idx_r <= 6'd43;
      mod_r      <= 3'd0;
      rcon_r     <= 8'h01;
      kw_valid   <= 1'b0;
      kw_data    <= 32'h0;
      kw_index   <= 6'd0;
      kw_last    <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_r    <= state_s;
      win_r      <= win_s;
      nk_r       <= nk_s;
      last_idx_r <= last_idx_s;
      mod_r      <= mod_s;
      rcon_r     <= rcon_s;
      kw_valid   <= kw_valid_s;
      kw_data    <= kw_data_s;
      kw_index   <= kw_index_s;
      kw_last    <= kw_last_s;
      err        <= err_s;
    end
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// Bench for aes_key_expander: FIPS-197 vectors, scoreboard against an
// independent log-table key-schedule model, backpressure, errors, reset.

module tb_aes_key_expander;

  logic         clk = 1'b0;
  logic         reset, start, kw_ready;
  logic [1:0]   mode;
  logic [255:0] key_in;
  logic         start_ready, kw_valid, kw_last, err;
  logic [31:0]  kw_data;
  logic [5:0]   kw_index;
  logic         start_b;
  logic [1:0]   mode_b;
  logic         start_ready_b, kw_valid_b, kw_last_b, err_b;
  logic [31:0]  kw_data_b;
  logic [5:0]   kw_index_b;

  always #5 clk = ~clk;

  aes_key_expander dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .key_in(key_in),
    .start_ready(start_ready), .kw_valid(kw_valid), .kw_ready(kw_ready),
    .kw_data(kw_data), .kw_index(kw_index), .kw_last(kw_last), .err(err)
  );

  aes_key_expander #(.ENABLE_192(1'b0), .ENABLE_256(1'b1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .mode(mode_b), .key_in(key_in),
    .start_ready(start_ready_b), .kw_valid(kw_valid_b), .kw_ready(kw_ready),
    .kw_data(kw_data_b), .kw_index(kw_index_b), .kw_last(kw_last_b), .err(err_b)
  );

  typedef struct {
    logic [1:0]   mode;
    logic [255:0] key;
    bit           rnd;
    int           nwords;
    int           ia;
    logic [31:0]  wa;
    int           ib;
    logic [31:0]  wb;
  } vec_t;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got [64];
  int          lg [256];
  logic [7:0]  alog [256];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  function automatic logic [7:0] m_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  task automatic init_tables();
    logic [7:0] p;
    p = 8'h01;
    for (int i = 0; i < 255; i++) begin
      alog[i] = p;
      lg[p]   = i;
      p = p ^ m_xtime(p);
    end
  endtask

  function automatic logic [7:0] m_sbox(input logic [7:0] x);
    logic [7:0] inv;
    if (x == 8'h00) inv = 8'h00;
    else inv = alog[(255 - lg[x]) % 255];
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] m_subword(input logic [31:0] t);
    return {m_sbox(t[31:24]), m_sbox(t[23:16]), m_sbox(t[15:8]), m_sbox(t[7:0])};
  endfunction

  task automatic model_expand(input logic [1:0] m, input logic [255:0] k);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc [10];
    int nk, nw;
    rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    nk = (m == 2'd0) ? 4 : ((m == 2'd1) ? 6 : 8);
    nw = 4 * nk + 28;
    exp_q.delete();
    for (int i = 0; i < nw; i++) begin
      if (i < nk) begin
        w[i] = k[255 - 32 * i -: 32];
      end else begin
        t = w[i - 1];
        if (i % nk == 0)
          t = m_subword({t[23:0], t[31:24]}) ^ {rc[i / nk - 1], 24'h000000};
        else if (nk == 8 && i % nk == 4)
          t = m_subword(t);
        w[i] = w[i - nk] ^ t;
      end
      exp_q.push_back(w[i]);
    end
  endtask

  // Start a job, then consume words until kw_last, scoring each handshake.
  task automatic run_job(input logic [1:0] m, input logic [255:0] k, input bit rnd,
                         output int valid_cycles, output int nwords_got);
    logic [31:0] exp_w;
    logic [38:0] held;
    bit          stalled, done;
    int          n, idx, guard;
    model_expand(m, k);
    n = exp_q.size();
    for (int j = 0; j < 64; j++) got[j] = 32'h0;
    start = 1'b1; mode = m; key_in = k;
    @(posedge clk); #1;
    start = 1'b0; mode = 2'd3; key_in = ~k;
    stalled = 1'b0; done = 1'b0; valid_cycles = 0; nwords_got = 0; guard = 0; held = '0;
    while (!done && guard < 1000) begin
      guard++;
      if (guard == 1) check("first_valid", kw_valid, 1'b1);
      if (stalled) check("stall_hold", {kw_data, kw_index, kw_last}, held);
      if (kw_valid) valid_cycles++;
      kw_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (kw_valid && kw_ready) begin
        idx = nwords_got;
        if (exp_q.size() == 0) begin
          check("queue_underflow", 1'b1, 1'b0);
          done = 1'b1;
        end else begin
          exp_w = exp_q.pop_front();
          check($sformatf("w%0d", idx), kw_data, exp_w);
          check($sformatf("idx_last%0d", idx), {kw_index, kw_last},
                {idx[5:0], (idx == n - 1)});
          if (idx < 64) got[idx] = kw_data;
          nwords_got++;
          if (kw_last) done = 1'b1;
        end
        stalled = 1'b0;
      end else if (kw_valid) begin
        stalled = 1'b1;
        held = {kw_data, kw_index, kw_last};
      end else begin
        stalled = 1'b0;
      end
      @(posedge clk); #1;
    end
    if (!done) check("job_timeout", 1'b0, 1'b1);
    kw_ready = 1'b1;
  endtask

  vec_t vecs [4];
  int   vc, nw;
  int   guard;

  initial begin
    vecs[0] = '{2'd0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1'b0, 44,
                4, 32'ha0fafe17, 43, 32'hb6630ca6};
    vecs[1] = '{2'd1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 1'b0, 52,
                6, 32'hfe0c91f7, 51, 32'h01002202};
    vecs[2] = '{2'd2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                1'b0, 60, 8, 32'h9ba35411, 12, 32'ha8b09c1a};
    vecs[3] = '{2'd2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                1'b1, 60, 59, 32'h706c631e, 12, 32'ha8b09c1a};
    init_tables();

    reset = 1'b1; start = 1'b0; mode = 2'd0; key_in = 256'h0; kw_ready = 1'b1;
    start_b = 1'b0; mode_b = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {start_ready, kw_valid, kw_data, kw_index, kw_last, err},
          {1'b1, 1'b0, 32'h0, 6'd0, 1'b0, 1'b0});
    reset = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 4; v++) begin
      run_job(vecs[v].mode, vecs[v].key, vecs[v].rnd, vc, nw);
      check($sformatf("v%0d_count", v), nw, vecs[v].nwords);
      check($sformatf("v%0d_w%0d", v, vecs[v].ia), got[vecs[v].ia], vecs[v].wa);
      check($sformatf("v%0d_w%0d", v, vecs[v].ib), got[vecs[v].ib], vecs[v].wb);
      if (!vecs[v].rnd) check($sformatf("v%0d_valid_cycles", v), vc, vecs[v].nwords);
      check($sformatf("v%0d_idle_after", v), {kw_valid, start_ready}, 2'b01);
    end

    // Illegal mode 3, then mode 1 on the 192-disabled instance.
    start = 1'b1; mode = 2'd3;
    @(posedge clk); #1;
    start = 1'b0;
    check("err3_pulse", {err, kw_valid, start_ready}, 3'b101);
    @(posedge clk); #1;
    check("err3_clear", {err, kw_valid, start_ready}, 3'b001);
    start_b = 1'b1; mode_b = 2'd1;
    @(posedge clk); #1;
    start_b = 1'b0;
    check("err192_pulse", {err_b, kw_valid_b, start_ready_b}, 3'b101);
    @(posedge clk); #1;
    check("err192_clear", {err_b, kw_valid_b, start_ready_b}, 3'b001);

    // Abort an AES-128 run at index 20, then restart immediately with AES-192.
    start = 1'b1; mode = 2'd0; key_in = vecs[0].key; kw_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (!(kw_valid && kw_index == 6'd20) && guard < 100) begin
      guard++;
      @(posedge clk); #1;
    end
    check("reach_idx20", {kw_valid, kw_index}, {1'b1, 6'd20});
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_reset_outputs", {start_ready, kw_valid, kw_data, kw_index, kw_last, err},
          {1'b1, 1'b0, 32'h0, 6'd0, 1'b0, 1'b0});
    run_job(2'd1, vecs[1].key, 1'b0, vc, nw);
    check("restart_w6", got[6], 32'hfe0c91f7);
    check("restart_count", nw, 52);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_key_expander.md
# aes_key_expander

Iterative AES key-schedule engine that generalises the single-word g-function (RotWord, SubWord, Rcon XOR) into a complete runtime-selectable AES-128/192/256 key expansion. It accepts a cipher key, then streams every expanded word w[0..4(Nr+1)-1] one per cycle over a valid/ready interface. It sits between key loading and the round-key store or cipher datapath, and reuses the existing `sbox` module through four instances.

## Interface
- ENABLE_192, default 1: when 0, mode 2'd1 is rejected as illegal.
- ENABLE_256, default 1: when 0, mode 2'd2 is rejected as illegal.
- clk  in  1  clock; reset is synchronous, active-high (signal `reset`).
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to begin an expansion; accepted only when start_ready=1.
- mode  in  2  key size: 0=AES-128 (Nk=4, 44 words), 1=AES-192 (Nk=6, 52 words), 2=AES-256 (Nk=8, 60 words), 3=illegal.
- key_in  in  256  key, MSB-first. Word k = key_in[255-32k -: 32]. AES-128 uses [255:128]; AES-192 uses [255:64].
- start_ready  out  1  high in IDLE.
- kw_valid  out  1  kw_data is valid.
- kw_ready  in  1  consumer accepts the word when kw_valid and kw_ready are both high.
- kw_data  out  32  expanded word; byte 0 is in [31:24].
- kw_index  out  6  index i of kw_data.
- kw_last  out  1  high with the final word (i = 43/51/59).
- err  out  1  one-cycle pulse when start is seen with an illegal or disabled mode.

## Operation
- The FSM has two states, IDLE and RUN.
- **IDLE:**
  - start_ready=1.
  - start with a legal mode:
    - latch Nk and the total word count;
    - load the key words into an 8-entry word window;
    - set i=0 and rcon=8'h01;
    - go to RUN.
  - start with an illegal mode: err=1 for one cycle and stay in IDLE.
- **RUN:**
  - Present w[i]. For i<Nk, w[i] is key word i.
  - For i≥Nk: temp=w[i-1].
    - If i mod Nk==0: temp=SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon←xtime(rcon). The sequence is 01,02,04,08,10,20,40,80,1b,36.
    - Else if Nk==8 and i mod Nk==4: temp=SubWord(temp).
    - w[i]=w[i-Nk]^temp.
  - RotWord is a left rotate by one byte. SubWord applies the sbox to each byte.
  - On handshake:
    - the window shifts in w[i];
    - i increments;
    - the modulo-Nk counter wraps at Nk-1 (no divider).
  - On handshake with kw_last: go to IDLE and drop kw_valid.
- **Stall:** while kw_valid && !kw_ready:
  - kw_data, kw_index and kw_last are held stable;
  - the window, rcon, i and the mod counter are frozen.
- start, mode and key_in are ignored in RUN. Changes to key_in after acceptance have no effect.

## Timing
- **Reset values:**
  - start_ready=1, kw_valid=0, kw_data=0, kw_index=0, kw_last=0, err=0;
  - internal: rcon=8'h01, window=0, state=IDLE.
- Reset asserted mid-RUN aborts the expansion; outputs take reset values on the next edge.
- kw_data is registered. start accepted at edge t gives kw_valid=1 with w[0] after edge t. Every cycle, kw_valid, kw_data, kw_index and kw_last reflect the registered state.
- With kw_ready held high, one word per cycle:
  - AES-128: last word at t+44;
  - AES-192: last word at t+52;
  - AES-256: last word at t+60.
- start_ready returns to 1 in the cycle after the kw_last handshake. A new start is accepted then, so there is one idle cycle between jobs.
- The next-word path (window → sbox ×4 → XOR → register) completes in one cycle. The sboxes are combinational and shared between the RotWord and plain SubWord cases.
- err fires on the edge after the illegal start and clears the following cycle.

## Test plan
- **AES-128:**
  - Stimulus: mode=0, key 2b7e1516 28aed2a6 abf71588 09cf4f3c, kw_ready=1.
  - Required: w4=a0fafe17, w43=b6630ca6, kw_last only at index 43, 44 consecutive valid cycles.
- **AES-192:**
  - Stimulus: mode=1, key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b.
  - Required: w6=fe0c91f7, w51=01002202, kw_last at index 51.
- **AES-256:**
  - Stimulus: mode=2, key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4.
  - Required: w8=9ba35411, w12=a8b09c1a (i mod 8 == 4 SubWord path), w59=706c631e.
- **Backpressure:**
  - Stimulus: AES-256 with kw_ready random at 50%, compared against a golden model.
  - Required: the word sequence is identical to the unstalled run, and kw_data is stable during every stall.
- **Illegal and disabled modes:**
  - Stimulus: mode=3; then mode=1 with ENABLE_192=0.
  - Required: one err pulse each, kw_valid stays 0, start_ready stays 1.
- **Reset and restart:**
  - Stimulus: reset asserted at index 20 of AES-128; then an immediate AES-192 start.
  - Required: all outputs return to reset values, and the new run starts at w0 with rcon=01 (w6=fe0c91f7).
